// File: rtl/i2s_pkg.sv
// Shared I2S framing constants and types for the master transmitter and related blocks.
package i2s_pkg;

  localparam int unsigned SAMPLE_W   = 24;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned MSB_OFFSET = 1;
  localparam int unsigned POS_W      = $clog2(FRAME_BITS);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [POS_W-1:0]    pos_t;

  typedef struct packed {
    sample_t lft;
    sample_t rght;
  } frame_t;

  // True when position p carries a sample bit of the slot starting at base.
  function automatic logic in_slot(pos_t p, int unsigned base);
    return (32'(p) >= base + MSB_OFFSET) && (32'(p) < base + MSB_OFFSET + SAMPLE_W);
  endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// Free-running I2S bit-clock generator: 2*SCLK_DIV clk per sclk period, with
// single-cycle rise/fall strobes asserted on the clk edge that moves sclk.
module i2s_sclk_gen #(
  parameter int unsigned SCLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic I2S_sclk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int unsigned CNT_W = $clog2(SCLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV - 1);

  logic [CNT_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             tc;

  assign tc = (div_q == CNT_LAST);

  always_comb begin
    div_d  = div_q + 1'b1;
    sclk_d = sclk_q;
    if (tc) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign I2S_sclk = sclk_q;
  assign rise_evt = tc & ~sclk_q;
  assign fall_evt = tc & sclk_q;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter (Philips format, 64 sclk/frame, 24-bit samples MSB-first).
// Optional underrun counter output undr_cnt enabled by I2S_TX_UNDERRUN_CNT_EN.
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] lft_chnnl,
  input  logic [SAMPLE_W-1:0] rght_chnnl,
  input  logic                vld,
  output logic                I2S_sclk,
  output logic                I2S_ws,
  output logic                I2S_data,
  output logic                frm_req,
  output logic                undr
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]          undr_cnt
`endif
);

  localparam pos_t POS_LAST = pos_t'(FRAME_BITS - 1);

  logic    rise_evt, fall_evt;
  logic    load;
  pos_t    pos_q, pos_d;
  frame_t  hold_q, hold_d;
  logic    full_q, full_d;
  sample_t lft_shft_q, lft_shft_d;
  sample_t rght_shft_q, rght_shft_d;
  logic    ws_q, ws_d;
  logic    data_q, data_d;
  logic    frm_req_q, frm_req_d;
  logic    undr_q, undr_d;

  i2s_sclk_gen #(
    .SCLK_DIV(SCLK_DIV)
  ) u_sclk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .I2S_sclk(I2S_sclk),
    .rise_evt(rise_evt),
    .fall_evt(fall_evt)
  );

  assign load = fall_evt && (pos_q == POS_LAST);

  always_comb begin
    pos_d       = pos_q;
    hold_d      = hold_q;
    full_d      = full_q;
    lft_shft_d  = lft_shft_q;
    rght_shft_d = rght_shft_q;
    ws_d        = ws_q;
    data_d      = data_q;
    frm_req_d   = 1'b0;
    undr_d      = 1'b0;

    if (fall_evt) begin
      pos_d  = pos_q + 1'b1;
      ws_d   = (32'(pos_d) >= SLOT_BITS);
      data_d = 1'b0;
      if (load) begin
        frm_req_d = 1'b1;
        undr_d    = ~full_q;
        if (full_q) begin
          lft_shft_d  = hold_q.lft;
          rght_shft_d = hold_q.rght;
          full_d      = 1'b0;
        end
      end else if (in_slot(pos_d, 0)) begin
        // Rotate rather than shift so an underrun frame can resend the same bits.
        data_d     = lft_shft_q[SAMPLE_W-1];
        lft_shft_d = {lft_shft_q[SAMPLE_W-2:0], lft_shft_q[SAMPLE_W-1]};
      end else if (in_slot(pos_d, SLOT_BITS)) begin
        data_d      = rght_shft_q[SAMPLE_W-1];
        rght_shft_d = {rght_shft_q[SAMPLE_W-2:0], rght_shft_q[SAMPLE_W-1]};
      end
    end

    // A strobe on the load edge lands after the load has taken the old contents.
    if (vld) begin
      hold_d.lft  = lft_chnnl;
      hold_d.rght = rght_chnnl;
      full_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= POS_LAST;
      hold_q      <= '0;
      full_q      <= 1'b0;
      lft_shft_q  <= '0;
      rght_shft_q <= '0;
      ws_q        <= 1'b1;
      data_q      <= 1'b0;
      frm_req_q   <= 1'b0;
      undr_q      <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      lft_shft_q  <= lft_shft_d;
      rght_shft_q <= rght_shft_d;
      ws_q        <= ws_d;
      data_q      <= data_d;
      frm_req_q   <= frm_req_d;
      undr_q      <= undr_d;
    end
  end

  assign I2S_ws   = ws_q;
  assign I2S_data = data_q;
  assign frm_req  = frm_req_q;
  assign undr     = undr_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [7:0] undr_cnt_q, undr_cnt_d;

  // A clearing strobe coincident with an underrun load leaves the count at 1.
  always_comb begin
    undr_cnt_d = undr_cnt_q;
    if (vld && !full_q && (undr_cnt_q != 8'h00)) begin
      undr_cnt_d = 8'h00;
    end
    if (load && !full_q && (undr_cnt_d != 8'hFF)) begin
      undr_cnt_d = undr_cnt_d + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      undr_cnt_q <= 8'h00;
    end else begin
      undr_cnt_q <= undr_cnt_d;
    end
  end

  assign undr_cnt = undr_cnt_q;
`endif

  a_evt_excl: assert property (@(posedge clk) disable iff (!rst_n) !(rise_evt && fall_evt));

endmodule
